// File: rtl/boot_loader.sv
// Stream-driven boot loader: decodes section headers, writes payload words into NUM_CH BRAMs
// and holds the core stalled until an END header. Optional build macro: CHECKSUM_EN.
module boot_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned NUM_CH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_dat,
  output logic [NUM_CH-1:0]     mem_w_enb,
  output logic                  cpu_stall,
  output logic                  boot_done,
  output logic                  boot_err,
  output logic [15:0]           words_loaded
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned IDXA_W = CNT_W + 2;
  localparam logic [CH_W-1:0]  CH_END  = 4'hF;
  localparam logic [CH_W-1:0]  CH_LIM  = CH_W'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t                  r_state;
  state_t                  w_nxt;
  logic                    r_s_ready;
  logic [CH_W-1:0]         r_ch;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_idx;
  logic [NUM_CH-1:0]       r_enb;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_stall;
  logic                    r_done;
  logic                    r_err;
  logic [15:0]             r_words;

  logic                    w_xfer;
  logic                    w_hdr_seen;
  logic                    w_hdr_take;
  logic                    w_wr;
  logic                    w_last;
  logic [CH_W-1:0]         w_hdr_ch;
  logic [CNT_W-1:0]        w_hdr_cnt;
  logic [IDXA_W-1:0]       w_byte_addr;

  assign w_xfer      = s_valid & r_s_ready;
  assign w_hdr_ch    = s_data[DATA_WIDTH-1 -: CH_W];
  assign w_hdr_cnt   = s_data[CNT_W-1:0];
  assign w_last      = (r_idx == (r_cnt - CNT_W'(1)));
  assign w_byte_addr = {r_idx, 2'b00};

`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_acc;
`endif

  // Next-state decode; strobes drive the datapath registers below
  always_comb begin
    w_nxt      = r_state;
    w_hdr_seen = 1'b0;
    w_hdr_take = 1'b0;
    w_wr       = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_xfer) begin
          w_hdr_seen = 1'b1;
          if (w_hdr_ch == CH_END) begin
            w_nxt = S_DONE;
          end else if ((w_hdr_ch >= CH_LIM) || (w_hdr_cnt > CNT_MAX)) begin
            w_nxt = S_ERR;
          end else if (w_hdr_cnt != '0) begin
            w_nxt      = S_LOAD;
            w_hdr_take = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_wr = 1'b1;
          if (w_last) begin
`ifdef CHECKSUM_EN
            w_nxt = S_CHK;
`else
            w_nxt = S_HDR;
`endif
          end
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) begin
          w_nxt = (s_data == r_acc) ? S_HDR : S_ERR;
        end
      end
`endif
      S_DONE:  w_nxt = S_DONE;
      S_ERR:   w_nxt = S_ERR;
      default: w_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Registered status outputs follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ready <= 1'b0;
      r_stall   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_s_ready <= !((w_nxt == S_DONE) || (w_nxt == S_ERR));
      r_stall   <= (w_nxt != S_DONE);
      r_done    <= (w_nxt == S_DONE);
      r_err     <= (w_nxt == S_ERR);
    end
  end

  // Section context and write-port pipeline stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch    <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_enb   <= '0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_words <= '0;
    end else begin
      r_enb <= '0;
      if (w_hdr_take) begin
        r_ch  <= w_hdr_ch;
        r_cnt <= w_hdr_cnt;
        r_idx <= '0;
      end
      if (w_wr) begin
        r_enb  <= NUM_CH'(1) << r_ch;
        r_addr <= ADDR_WIDTH'(w_byte_addr);
        r_dat  <= s_data;
        r_idx  <= r_idx + CNT_W'(1);
        if (r_words != 16'hFFFF) begin
          r_words <= r_words + 16'd1;
        end
      end
    end
  end

`ifdef CHECKSUM_EN
  // Running XOR of the current section's payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_hdr_seen) begin
      r_acc <= '0;
    end else if (w_wr) begin
      r_acc <= r_acc ^ s_data;
    end
  end
`endif

  assign s_ready      = r_s_ready;
  assign mem_w_addr   = r_addr;
  assign mem_w_dat    = r_dat;
  assign mem_w_enb    = r_enb;
  assign cpu_stall    = r_stall;
  assign boot_done    = r_done;
  assign boot_err     = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes queued at send time, popped on each write pulse.
module tb_boot_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned DEP = 256;
  localparam int unsigned NCH = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [DW-1:0]  s_data = '0;
  logic [AW-1:0]  mem_w_addr;
  logic [DW-1:0]  mem_w_dat;
  logic [NCH-1:0] mem_w_enb;
  logic           cpu_stall;
  logic           boot_done;
  logic           boot_err;
  logic [15:0]    words_loaded;

  typedef struct packed {
    logic [NCH-1:0] enb;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  dat;
  } wr_t;

  wr_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .NUM_CH(NCH)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
    .cpu_stall(cpu_stall), .boot_done(boot_done), .boot_err(boot_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && mem_w_enb != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'(mem_w_enb), 64'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_enb",  64'(mem_w_enb),  64'(e.enb));
        check("wr_addr", 64'(mem_w_addr), 64'(e.addr));
        check("wr_dat",  64'(mem_w_dat),  64'(e.dat));
      end
    end
  end

  function automatic logic [DW-1:0] hdr(input logic [3:0] ch, input logic [15:0] cnt);
    logic [DW-1:0] h;
    h = '0;
    h[DW-1 -: 4] = ch;
    h[15:0] = cnt;
    return h;
  endfunction

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(s_ready),      64'd0);
    check("rst_enb",   64'(mem_w_enb),    64'd0);
    check("rst_addr",  64'(mem_w_addr),   64'd0);
    check("rst_dat",   64'(mem_w_dat),    64'd0);
    check("rst_stall", 64'(cpu_stall),    64'd1);
    check("rst_done",  64'(boot_done),    64'd0);
    check("rst_err",   64'(boot_err),     64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one word until accepted; optional idle cycles afterwards
  task automatic send_word(input logic [DW-1:0] d, input int gap);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_section(input logic [3:0] ch, input logic [DW-1:0] w[$],
                              input int gap, input bit bad_ck);
    logic [DW-1:0] ck;
    wr_t e;
    ck = '0;
    send_word(hdr(ch, 16'(w.size())), gap);
    foreach (w[i]) begin
      e.enb  = NCH'(1) << ch;
      e.addr = AW'(i * 4);
      e.dat  = w[i];
      sb_q.push_back(e);
      ck = ck ^ w[i];
      send_word(w[i], gap);
    end
    if (bad_ck) ck = ~ck;
`ifdef CHECKSUM_EN
    send_word(ck, gap);
`endif
  endtask

  task automatic check_status(input string tag, input bit done, input bit err, input int words);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_done"},  64'(boot_done),    64'(done));
    check({tag, "_err"},   64'(boot_err),     64'(err));
    check({tag, "_stall"}, 64'(cpu_stall),    64'(!done));
    check({tag, "_ready"}, 64'(s_ready),      64'(!(done || err)));
    check({tag, "_words"}, 64'(words_loaded), 64'(words));
    check({tag, "_sb"},    64'(sb_q.size()),  64'd0);
  endtask

  logic [DW-1:0] w[$];
  logic [DW-1:0] wp[$];
  wr_t           e;

  initial begin
    // 1: single instruction section then END
    do_reset();
    w = {32'h00000093, 32'h00100113, 32'h002081b3};
    send_section(4'h0, w, 0, 1'b0);
    send_word(hdr(4'hF, 16'd0), 0);
    check_status("t1", 1'b1, 1'b0, 3);

    // 2: data section then six-word program
    do_reset();
    w = {32'h00000003, 32'h00000001};
    send_section(4'h1, w, 0, 1'b0);
    wp = {32'h00000293, 32'h00100313, 32'h0062f3b3, 32'h0062e433, 32'h0053f4b3, 32'h00000013};
    send_section(4'h0, wp, 0, 1'b0);
    send_word(hdr(4'hF, 16'd0), 0);
    check_status("t2", 1'b1, 1'b0, 8);

    // 3: channel out of range; later words must not be taken
    do_reset();
    send_word(hdr(4'h2, 16'd1), 0);
    s_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check_status("t3", 1'b0, 1'b1, 0);

    // 4: count over DEPTH errors; empty section skipped; DEPTH itself accepted
    do_reset();
    send_word(hdr(4'h0, 16'(DEP + 1)), 0);
    check_status("t4a", 1'b0, 1'b1, 0);
    do_reset();
    send_word(hdr(4'h0, 16'd0), 0);
    send_word(hdr(4'hF, 16'd0), 0);
    check_status("t4b", 1'b1, 1'b0, 0);
    do_reset();
    w.delete();
    for (int i = 0; i < int'(DEP); i++) w.push_back($urandom);
    send_section(4'h1, w, 0, 1'b0);
    send_word(hdr(4'hF, 16'd0), 0);
    check_status("t4c", 1'b1, 1'b0, DEP);

    // 5: valid toggling between every word
    do_reset();
    w = {$urandom, $urandom, $urandom, $urandom};
    send_section(4'h0, w, 1, 1'b0);
    send_word(hdr(4'hF, 16'd0), 1);
    check_status("t5", 1'b1, 1'b0, 4);

    // 6: reset mid-section, then reload from the start
    do_reset();
    w = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_word(hdr(4'h0, 16'd4), 0);
    for (int i = 0; i < 2; i++) begin
      e.enb  = NCH'(1);
      e.addr = AW'(i * 4);
      e.dat  = w[i];
      sb_q.push_back(e);
      send_word(w[i], 0);
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_partial_words", 64'(words_loaded), 64'd2);
    check("t6_partial_sb",    64'(sb_q.size()),  64'd0);
    do_reset();
    send_section(4'h0, w, 0, 1'b0);
    send_word(hdr(4'hF, 16'd0), 0);
    check_status("t6", 1'b1, 1'b0, 4);
`ifdef CHECKSUM_EN
    do_reset();
    send_section(4'h0, w, 0, 1'b1);
    check_status("t6_badck", 1'b0, 1'b1, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
